// File: rtl/aes_key_exp_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_exp_multi_pkg
// Brief    : Shared types, key-length lookups, S-box and xtime for the
//            word-serial AES key expander. KEY_EXP_STATE_CHK_EN selects the
//            one-hot state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package aes_key_exp_multi_pkg;

   typedef enum logic [1:0] {
      KEY_128  = 2'b00,
      KEY_192  = 2'b01,
      KEY_256  = 2'b10,
      KEY_RSVD = 2'b11
   } key_len_e;

`ifdef KEY_EXP_STATE_CHK_EN
   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_GEN  = 3'b010,
      ST_OUT  = 3'b100
   } state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GEN  = 2'd1,
      ST_OUT  = 2'd2
   } state_e;
`endif

   localparam logic [7:0] c_sbox [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return c_sbox[b];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [3:0] nk_of(input key_len_e kl);
      case (kl)
         KEY_192: return 4'd6;
         KEY_256: return 4'd8;
         default: return 4'd4;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(input key_len_e kl);
      case (kl)
         KEY_192: return 4'd12;
         KEY_256: return 4'd14;
         default: return 4'd10;
      endcase
   endfunction

   function automatic int key_bits_of(input key_len_e kl);
      case (kl)
         KEY_128: return 128;
         KEY_192: return 192;
         KEY_256: return 256;
         default: return 0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_exp_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_exp_multi_if
// Brief    : Job request and round-key stream channel of the key expander.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_key_exp_multi_if #(
   parameter int RKI_W = 4
) ();
   logic             start;
   logic [1:0]       key_len;
   logic [255:0]     key;
   logic             abort;
   logic             rk_ready;
   logic             busy;
   logic             rk_valid;
   logic [127:0]     rk_data;
   logic [RKI_W-1:0] rk_index;
   logic             rk_last;
   logic             done;
   logic             cmd_err;

   modport master (
      output start, key_len, key, abort, rk_ready,
      input  busy, rk_valid, rk_data, rk_index, rk_last, done, cmd_err
   );

   modport slave (
      input  start, key_len, key, abort, rk_ready,
      output busy, rk_valid, rk_data, rk_index, rk_last, done, cmd_err
   );
endinterface
`default_nettype wire

// File: rtl/aes_key_exp_multi_sub_word.sv
`default_nettype none
// ============================================================================
// Module   : aes_sub_word
// Brief    : Combinational SubWord: AES S-box applied to each byte of a word.
// Revision : 1.0 - initial release
// ============================================================================
module aes_sub_word
   import aes_key_exp_multi_pkg::*;
(
   input  logic [31:0] i_word,
   output logic [31:0] o_word
);
   for (genvar b = 0; b < 4; b++) begin : g_byte
      assign o_word[8*b +: 8] = sbox(i_word[8*b +: 8]);
   end
endmodule
`default_nettype wire

// File: rtl/aes_key_exp_multi.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_exp_multi
// Brief    : Word-serial AES-128/192/256 key expansion streaming Nr+1 round
//            keys. KEY_EXP_STATE_CHK_EN adds one-hot state checking.
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_exp_multi
   import aes_key_exp_multi_pkg::*;
#(
   parameter int MAX_KEY_BITS = 256,
   parameter int RKI_W        = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   aes_key_exp_multi_if.slave kx
`ifdef KEY_EXP_STATE_CHK_EN
   ,
   output logic               o_state_error
`endif
);

   state_e           r_state;
   logic             r_busy;
   logic [255:0]     r_key;
   logic [3:0]       r_nk;
   logic [RKI_W-1:0] r_nr;
   logic [5:0]       r_word_i;
   logic [2:0]       r_mod;
   logic [7:0]       r_rcon;
   logic [31:0]      r_win [8];
   logic [95:0]      r_col;
   logic [1:0]       r_slot;
   logic [RKI_W-1:0] r_round;
   logic             r_rk_valid;
   logic [127:0]     r_rk_data;
   logic [RKI_W-1:0] r_rk_index;
   logic             r_rk_last;
   logic             r_done;
   logic             r_cmd_err;

   logic             w_ok;
   logic             w_first;
   logic [2:0]       w_key_sel;
   logic [31:0]      w_key_word;
   logic [31:0]      w_sub_in;
   logic [31:0]      w_sub_out;
   logic [31:0]      w_temp;
   logic [31:0]      w_back;
   logic [31:0]      w_new;

   assign w_ok = (key_len_e'(kx.key_len) != KEY_RSVD) &&
                 (key_bits_of(key_len_e'(kx.key_len)) <= MAX_KEY_BITS);

   // The first Nk words come straight from the latched key.
   assign w_first    = ({2'b00, r_nk} > r_word_i);
   assign w_key_sel  = 3'd7 - r_word_i[2:0];
   assign w_key_word = r_key[{w_key_sel, 5'd0} +: 32];

   assign w_sub_in = (r_mod == 3'd0) ? {r_win[0][23:0], r_win[0][31:24]} : r_win[0];

   aes_sub_word u_sub_word (
      .i_word (w_sub_in),
      .o_word (w_sub_out)
   );

   always_comb begin
      w_temp = r_win[0];
      if (r_mod == 3'd0)
         w_temp = w_sub_out ^ {r_rcon, 24'h0};
      else if (r_nk == 4'd8 && r_mod == 3'd4)
         w_temp = w_sub_out;
   end

   always_comb begin
      case (r_nk)
         4'd6:    w_back = r_win[5];
         4'd8:    w_back = r_win[7];
         default: w_back = r_win[3];
      endcase
   end

   assign w_new = w_first ? w_key_word : (w_back ^ w_temp);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_busy     <= 1'b0;
         r_key      <= '0;
         r_nk       <= '0;
         r_nr       <= '0;
         r_word_i   <= '0;
         r_mod      <= '0;
         r_rcon     <= '0;
         for (int k = 0; k < 8; k++) r_win[k] <= '0;
         r_col      <= '0;
         r_slot     <= '0;
         r_round    <= '0;
         r_rk_valid <= 1'b0;
         r_rk_data  <= '0;
         r_rk_index <= '0;
         r_rk_last  <= 1'b0;
         r_done     <= 1'b0;
         r_cmd_err  <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_cmd_err <= 1'b0;
         if (kx.abort) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_rk_valid <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (kx.start) begin
                     if (w_ok) begin
                        r_key    <= kx.key;
                        r_nk     <= nk_of(key_len_e'(kx.key_len));
                        r_nr     <= RKI_W'(nr_of(key_len_e'(kx.key_len)));
                        r_word_i <= '0;
                        r_mod    <= '0;
                        r_rcon   <= 8'h01;
                        r_slot   <= '0;
                        r_round  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_GEN;
                     end else begin
                        r_cmd_err <= 1'b1;
                     end
                  end
               end
               ST_GEN: begin
                  r_win[0] <= w_new;
                  for (int k = 1; k < 8; k++) r_win[k] <= r_win[k-1];
                  r_word_i <= r_word_i + 6'd1;
                  if ({1'b0, r_mod} == r_nk - 4'd1)
                     r_mod <= '0;
                  else
                     r_mod <= r_mod + 3'd1;
                  if (!w_first && r_mod == 3'd0)
                     r_rcon <= xtime(r_rcon);
                  // Collector runs on its own 4-word cadence, independent of Nk.
                  r_slot <= r_slot + 2'd1;
                  r_col  <= {r_col[63:0], w_new};
                  if (r_slot == 2'd3) begin
                     r_rk_data  <= {r_col, w_new};
                     r_rk_valid <= 1'b1;
                     r_rk_index <= r_round;
                     r_rk_last  <= (r_round == r_nr);
                     r_round    <= r_round + 1'b1;
                     r_state    <= ST_OUT;
                  end
               end
               ST_OUT: begin
                  if (kx.rk_ready) begin
                     r_rk_valid <= 1'b0;
                     if (r_rk_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= ST_GEN;
                     end
                  end
               end
               default: begin
                  r_state    <= ST_IDLE;
                  r_busy     <= 1'b0;
                  r_rk_valid <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef KEY_EXP_STATE_CHK_EN
   assign o_state_error = !$onehot(r_state);
`endif

   assign kx.busy     = r_busy;
   assign kx.rk_valid = r_rk_valid;
   assign kx.rk_data  = r_rk_data;
   assign kx.rk_index = r_rk_index;
   assign kx.rk_last  = r_rk_last;
   assign kx.done     = r_done;
   assign kx.cmd_err  = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_exp_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_exp_multi
// Brief    : Directed vector bench for aes_key_exp_multi.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_exp_multi;
   import aes_key_exp_multi_pkg::*;

   logic clk;
   logic reset_n;
`ifdef KEY_EXP_STATE_CHK_EN
   logic state_err;
`endif

   aes_key_exp_multi_if #(.RKI_W(4)) kx ();

   aes_key_exp_multi #(
      .MAX_KEY_BITS (256),
      .RKI_W        (4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .kx      (kx)
`ifdef KEY_EXP_STATE_CHK_EN
      ,
      .o_state_error (state_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   kl;
      logic [255:0] key;
      int           n;
      logic [127:0] rk0;
      logic [127:0] rk2;
      logic [127:0] rkl;
      int           last_cyc;
   } vec_t;

   vec_t         vecs [3];
   logic [127:0] got  [16];
   logic [127:0] ref3 [16];

   int total = 0;
   int bad   = 0;

   int n_hs, first_cyc, last_cyc, done_cnt, done_cyc;
   int stall_bad, idx_bad, last_flag_cnt, last_flag_idx, err_seen;

   task automatic chk_i(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_v(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Runs one job; a stray start and a key change mid-job must have no effect.
   task automatic run_job(input logic [1:0] kl, input logic [255:0] k, input bit rnd);
      bit           prev_stall;
      logic [127:0] prev_data;
      logic [3:0]   prev_idx;
      int           cyc;
      n_hs = 0; first_cyc = -1; last_cyc = -1; done_cnt = 0; done_cyc = -1;
      stall_bad = 0; idx_bad = 0; last_flag_cnt = 0; last_flag_idx = -1; err_seen = 0;
      prev_stall = 1'b0; prev_data = '0; prev_idx = '0;
      @(negedge clk);
      kx.key_len = kl; kx.key = k; kx.start = 1'b1;
      @(negedge clk);
      kx.start = 1'b0; kx.key = ~k;
      cyc = 0;
      while (cyc < 400) begin
         kx.start   = (cyc == 7);
         kx.key_len = 2'b00;
         if (kx.done) begin done_cnt++; done_cyc = cyc; end
         if (kx.cmd_err) err_seen++;
         if (prev_stall && (!kx.rk_valid || kx.rk_data !== prev_data || kx.rk_index !== prev_idx))
            stall_bad++;
         kx.rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (kx.rk_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (kx.rk_ready) begin
               if (n_hs < 16) got[n_hs] = kx.rk_data;
               if (int'(kx.rk_index) != n_hs) idx_bad++;
               if (kx.rk_last) begin last_flag_cnt++; last_flag_idx = n_hs; end
               last_cyc = cyc;
               n_hs++;
            end
         end
         prev_stall = kx.rk_valid && !kx.rk_ready;
         prev_data  = kx.rk_data;
         prev_idx   = kx.rk_index;
         if (done_cnt > 0 && cyc >= done_cyc + 2) break;
         @(negedge clk);
         cyc++;
      end
      kx.start = 1'b0;
      chk_i("job_timeout", int'(cyc >= 400), 0);
   endtask

   task automatic check_job(input int vi, input bit rnd);
      int n;
      n = vecs[vi].n;
      run_job(vecs[vi].kl, vecs[vi].key, rnd);
      chk_i("handshakes", n_hs, n);
      chk_v("rk0", got[0], vecs[vi].rk0);
      chk_v("rk2", got[2], vecs[vi].rk2);
      chk_v("rk_final", got[n-1], vecs[vi].rkl);
      chk_i("rk_last_count", last_flag_cnt, 1);
      chk_i("rk_last_pos", last_flag_idx, n - 1);
      chk_i("done_count", done_cnt, 1);
      chk_i("done_after_last", done_cyc, last_cyc + 1);
      chk_i("index_seq_errs", idx_bad, 0);
      chk_i("stall_unstable", stall_bad, 0);
      chk_i("cmd_err_in_job", err_seen, 0);
      if (!rnd) begin
         chk_i("first_valid_cyc", first_cyc, 4);
         chk_i("last_valid_cyc", last_cyc, vecs[vi].last_cyc);
      end
   endtask

   initial begin
      int mism;
      bit found;
      vecs[0] = '{2'b00, {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0}, 11,
                  128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
                  128'hf2c295f2_7a96b943_5935807a_7359f67f,
                  128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, 54};
      vecs[1] = '{2'b01, {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'h0}, 13,
                  128'h8e73b0f7_da0e6452_c810f32b_809079e5,
                  128'hec12068e_6c827f6b_0e7a95b9_5c56fec2,
                  128'he98ba06f_448c773c_8ecc7204_01002202, 64};
      vecs[2] = '{2'b10, 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4, 15,
                  128'h603deb10_15ca71be_2b73aef0_857d7781,
                  128'h9ba35411_8e6925af_a51a8b5f_2067fcde,
                  128'hfe4890d1_e6188d0b_046df344_706c631e, 74};

      reset_n = 1'b0;
      kx.start = 1'b0; kx.key_len = 2'b00; kx.key = '0; kx.abort = 1'b0; kx.rk_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk_i("reset_flags", int'({kx.busy, kx.rk_valid, kx.rk_last, kx.done, kx.cmd_err, kx.rk_index}), 0);
      chk_v("reset_rk_data", kx.rk_data, '0);
      reset_n = 1'b1;

      for (int v = 0; v < 3; v++) check_job(v, 1'b0);
      for (int i = 0; i < 15; i++) ref3[i] = got[i];

      // Backpressure on the 256-bit vector
      check_job(2, 1'b1);
      mism = 0;
      for (int i = 0; i < 15; i++) if (got[i] !== ref3[i]) mism++;
      chk_i("bp_keys_match", mism, 0);

      // Abort at round 5, abort wins over the concurrent handshake
      @(negedge clk);
      kx.key_len = 2'b00; kx.key = vecs[0].key; kx.start = 1'b1;
      @(negedge clk);
      kx.start = 1'b0; kx.rk_ready = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (kx.rk_valid && kx.rk_index == 4'd5) begin found = 1'b1; break; end
         @(negedge clk);
      end
      chk_i("abort_reached_idx5", int'(found), 1);
      kx.abort = 1'b1;
      @(negedge clk);
      kx.abort = 1'b0;
      chk_i("abort_valid", int'(kx.rk_valid), 0);
      chk_i("abort_busy", int'(kx.busy), 0);
      mism = 0;
      for (int c = 0; c < 4; c++) begin
         if (kx.done || kx.rk_valid) mism++;
         @(negedge clk);
      end
      chk_i("abort_no_done", mism, 0);
      check_job(0, 1'b0);

      // Reserved key length
      kx.key_len = 2'b11; kx.start = 1'b1;
      @(negedge clk);
      kx.start = 1'b0;
      chk_i("cmd_err_pulse", int'(kx.cmd_err), 1);
      chk_i("cmd_err_busy", int'(kx.busy), 0);
      @(negedge clk);
      chk_i("cmd_err_one_cycle", int'(kx.cmd_err), 0);
      chk_i("cmd_err_still_idle", int'(kx.busy), 0);

      // Asynchronous reset mid-job
      kx.key_len = 2'b01; kx.key = vecs[1].key; kx.start = 1'b1;
      @(negedge clk);
      kx.start = 1'b0;
      repeat (20) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk_i("async_reset_flags", int'({kx.busy, kx.rk_valid, kx.rk_last, kx.done, kx.cmd_err, kx.rk_index}), 0);
      chk_v("async_reset_data", kx.rk_data, '0);
      @(negedge clk);
      reset_n = 1'b1;
      check_job(1, 1'b0);

`ifdef KEY_EXP_STATE_CHK_EN
      @(negedge clk);
      chk_i("state_err_idle", int'(state_err), 0);
      force dut.r_state = state_e'(3'b011);
      #1;
      chk_i("state_err_raised", int'(state_err), 1);
      release dut.r_state;
      @(negedge clk);
      chk_i("state_err_cleared", int'(state_err), 0);
      chk_i("state_err_busy", int'(kx.busy), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
